// File: rtl/field_sram_writer.sv
// Playfield SRAM write engine: queues cell paints and whole-field clears, issuing
// SRAM write cycles only during blanking. Optional macro: FIELD_WR_BOUNDS_CHECK_EN.
module field_sram_writer #(
  parameter int COLS       = 20,
  parameter int ROWS       = 22,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        VGA_CTRL_CLK,
  input  logic        RST,
  input  logic        blank_i,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_x,
  input  logic [4:0]  wr_y,
  input  logic [11:0] wr_color,
  input  logic        clr_start,
  input  logic [11:0] clr_color,
  output logic        busy,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
`ifdef FIELD_WR_BOUNDS_CHECK_EN
  output logic        sram_own,
  output logic        err_oob
`else
  output logic        sram_own
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [4:0] X_LAST = 5'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  typedef struct packed {
    logic [4:0]  x;
    logic [4:0]  y;
    logic [11:0] color;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t state, state_n;

  // ---------------------------------------------------------------- request queue
  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;
  logic            q_nonempty;
  entry_t          head;

  assign wr_ready   = (count != FULL_COUNT);
  assign push       = wr_valid && wr_ready;
  assign q_nonempty = (count != '0);
  assign head       = mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked solely by count.
  always_ff @(posedge VGA_CTRL_CLK) begin
    if (push) begin
      mem[wr_ptr] <= '{x: wr_x, y: wr_y, color: wr_color};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- clear sweep
  logic        clr_active;
  logic [4:0]  clr_x, clr_y;
  logic [11:0] clr_color_q;
  logic        clr_step;

  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST) begin
      clr_active  <= 1'b0;
      clr_x       <= '0;
      clr_y       <= '0;
      clr_color_q <= '0;
    end else if (clr_start && !clr_active) begin
      clr_active  <= 1'b1;
      clr_x       <= '0;
      clr_y       <= '0;
      clr_color_q <= clr_color;
    end else if (clr_step) begin
      // Row-major sweep; the final cell's write retires the clear.
      if (clr_x == X_LAST) begin
        clr_x <= '0;
        if (clr_y == Y_LAST) clr_active <= 1'b0;
        else                 clr_y      <= clr_y + 1'b1;
      end else begin
        clr_x <= clr_x + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- bounds check
  logic head_oob;
`ifdef FIELD_WR_BOUNDS_CHECK_EN
  localparam logic [5:0] COLS_W = 6'(COLS);
  localparam logic [5:0] ROWS_W = 6'(ROWS);
  assign head_oob = ({1'b0, head.x} >= COLS_W) || ({1'b0, head.y} >= ROWS_W);
`else
  assign head_oob = 1'b0;
`endif

  // ---------------------------------------------------------------- write FSM
  logic q_take;
  logic load, load_clr;

  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    load     = 1'b0;
    load_clr = 1'b0;
    clr_step = 1'b0;
    q_take   = 1'b0;
    case (state)
      S_IDLE: begin
        if (blank_i && clr_active) begin
          state_n  = S_SETUP;
          load     = 1'b1;
          load_clr = 1'b1;
          clr_step = 1'b1;
        end else if (blank_i && q_nonempty) begin
          q_take = 1'b1;
          pop    = 1'b1;
          if (!head_oob) begin
            state_n = S_SETUP;
            load    = 1'b1;
          end
        end
      end
      S_SETUP:  state_n = S_STROBE;
      S_STROBE: state_n = S_HOLD;
      S_HOLD:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  logic [17:0] addr_q;
  logic [15:0] data_q;

  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (load) begin
      if (load_clr) begin
        addr_q <= {clr_x, clr_y, 8'h00};
        data_q <= {clr_color_q, 4'h0};
      end else begin
        addr_q <= {head.x, head.y, 8'h00};
        data_q <= {head.color, 4'h0};
      end
    end
  end

`ifdef FIELD_WR_BOUNDS_CHECK_EN
  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST)                   err_oob <= 1'b0;
    else if (q_take && head_oob) err_oob <= 1'b1;
  end
`endif

  // Bus ownership is kept through the idle gap when the next write starts
  // back-to-back, so the top-level mux does not toggle between cells.
  assign sram_own    = (state != S_IDLE) || load;
  assign sram_dq_oe  = (state != S_IDLE) || load;
  assign sram_we_n   = (state != S_STROBE);
  assign sram_addr   = addr_q;
  assign sram_dq_out = data_q;
  assign busy        = clr_active || q_nonempty || (state != S_IDLE);

endmodule

// File: tb/tb_field_sram_writer.sv
// Self-checking bench for field_sram_writer: table-driven single writes plus
// hand-written blanking, backpressure, clear and reset sequences.
module tb_field_sram_writer;

  logic        VGA_CTRL_CLK;
  logic        RST;
  logic        blank_i;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_x, wr_y;
  logic [11:0] wr_color;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        busy;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_own;
`ifdef FIELD_WR_BOUNDS_CHECK_EN
  logic        err_oob;
`endif

  field_sram_writer #(.COLS(20), .ROWS(22), .FIFO_DEPTH(8)) dut (
    .VGA_CTRL_CLK(VGA_CTRL_CLK),
    .RST         (RST),
    .blank_i     (blank_i),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .clr_start   (clr_start),
    .clr_color   (clr_color),
    .busy        (busy),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
`ifdef FIELD_WR_BOUNDS_CHECK_EN
    .sram_own    (sram_own),
    .err_oob     (err_oob)
`else
    .sram_own    (sram_own)
`endif
  );

  initial VGA_CTRL_CLK = 1'b0;
  always #5 VGA_CTRL_CLK = ~VGA_CTRL_CLK;

  typedef struct {
    logic [4:0]  x;
    logic [4:0]  y;
    logic [11:0] c;
    logic [17:0] ea;
    logic [15:0] ed;
  } vec_t;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   strobes = 0;
  int   last_strobe_cyc = -100;
  int   strobe_cyc[$];
  int   push_cyc = 0;
  bit   prev_low = 1'b0;
  exp_t sb[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge VGA_CTRL_CLK) cyc <= cyc + 1;

  // Write monitor: every strobe cycle is matched against the scoreboard.
  always @(negedge VGA_CTRL_CLK) begin
    if (!RST) begin
      prev_low = 1'b0;
    end else begin
      if (!sram_we_n) begin
        strobes++;
        last_strobe_cyc = cyc;
        strobe_cyc.push_back(cyc);
        check("strobe_width", {31'b0, prev_low}, 32'd0);
        check("strobe_own_oe", {30'b0, sram_own, sram_dq_oe}, 32'd3);
        check("unexpected_write", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("write_addr", {14'b0, sram_addr}, {14'b0, e.a});
          check("write_data", {16'b0, sram_dq_out}, {16'b0, e.d});
        end
      end
      prev_low = !sram_we_n;
    end
  end

  task automatic push_entry(input logic [4:0] x, input logic [4:0] y, input logic [11:0] c,
                            input bit expect_write, output bit accepted);
    @(negedge VGA_CTRL_CLK);
    wr_valid = 1'b1;
    wr_x     = x;
    wr_y     = y;
    wr_color = c;
    accepted = wr_ready;
    if (accepted && expect_write) sb.push_back('{{x, y, 8'h00}, {c, 4'h0}});
    @(negedge VGA_CTRL_CLK);
    push_cyc = cyc;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n;
    n = 0;
    do begin
      @(negedge VGA_CTRL_CLK);
      n++;
    end while (busy && n < max_cycles);
    check(name, {31'b0, busy}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic wait_strobe(input int max_cycles);
    int n;
    n = 0;
    while (sram_we_n && n < max_cycles) begin
      @(negedge VGA_CTRL_CLK);
      n++;
    end
    check("strobe_seen", {31'b0, sram_we_n}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int s0;

    vecs[0] = '{5'd4,  5'd0,  12'h0FF, 18'h08000, 16'h0FF0};
    vecs[1] = '{5'd2,  5'd0,  12'h123, 18'h04000, 16'h1230};
    vecs[2] = '{5'd0,  5'd0,  12'h000, 18'h00000, 16'h0000};
    vecs[3] = '{5'd19, 5'd21, 12'hABC, 18'h27500, 16'hABC0};
    vecs[4] = '{5'd10, 5'd5,  12'h5A5, 18'h14500, 16'h5A50};
    vecs[5] = '{5'd0,  5'd21, 12'hFFF, 18'h01500, 16'hFFF0};

    RST = 1'b0; blank_i = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0;
    wr_color = '0; clr_start = 1'b0; clr_color = '0;

    // Reset state
    @(negedge VGA_CTRL_CLK);
    @(negedge VGA_CTRL_CLK);
    check("rst_we_n",  {31'b0, sram_we_n}, 32'd1);
    check("rst_oe",    {31'b0, sram_dq_oe}, 32'd0);
    check("rst_own",   {31'b0, sram_own}, 32'd0);
    check("rst_addr",  {14'b0, sram_addr}, 32'd0);
    check("rst_data",  {16'b0, sram_dq_out}, 32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, wr_ready}, 32'd1);
    RST = 1'b1;

    // Table-driven single writes with blanking open
    blank_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      last_strobe_cyc = -100;
      push_entry(vecs[i].x, vecs[i].y, vecs[i].c, 1'b0, acc);
      check("vec_accept", {31'b0, acc}, 32'd1);
      sb.push_back('{vecs[i].ea, vecs[i].ed});
      wait_idle(20, "vec_idle");
      check("strobe_latency", last_strobe_cyc - push_cyc, 32'd2);
      check("idle_outputs", {29'b0, sram_own, sram_dq_oe, sram_we_n}, 32'd1);
    end

    // Blank gating: queued entries wait, then drain 4 clocks apart
    blank_i = 1'b0;
    push_entry(5'd1, 5'd2, 12'h111, 1'b1, acc);
    push_entry(5'd3, 5'd4, 12'h222, 1'b1, acc);
    push_entry(5'd5, 5'd6, 12'h333, 1'b1, acc);
    s0 = strobes;
    repeat (6) @(negedge VGA_CTRL_CLK);
    check("gated_no_write", strobes - s0, 32'd0);
    check("gated_ready", {31'b0, wr_ready}, 32'd1);
    check("gated_busy", {31'b0, busy}, 32'd1);
    strobe_cyc.delete();
    blank_i = 1'b1;
    wait_idle(40, "gate_idle");
    check("gate_count", strobe_cyc.size(), 32'd3);
    if (strobe_cyc.size() == 3) begin
      check("gate_spacing_1", strobe_cyc[1] - strobe_cyc[0], 32'd4);
      check("gate_spacing_2", strobe_cyc[2] - strobe_cyc[1], 32'd4);
    end

    // Backpressure: 9 pushes into an 8-deep queue
    blank_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      push_entry(5'(k), 5'(k + 1), 12'(12'h700 + k), 1'b1, acc);
      check((k < 8) ? "bp_accept" : "bp_reject", {31'b0, acc}, (k < 8) ? 32'd1 : 32'd0);
      if (k == 7) check("bp_full", {31'b0, wr_ready}, 32'd0);
    end
    blank_i = 1'b1;
    @(negedge VGA_CTRL_CLK);
    blank_i = 1'b0;
    check("bp_ready_after_pop", {31'b0, wr_ready}, 32'd1);
    s0 = strobes;
    repeat (8) @(negedge VGA_CTRL_CLK);
    check("bp_single_write", strobes - s0, 32'd1);
    blank_i = 1'b1;
    wait_idle(60, "bp_idle");

    // blank_i drops during STROBE: HOLD completes, next write waits
    blank_i = 1'b0;
    push_entry(5'd7, 5'd8,  12'h321, 1'b1, acc);
    push_entry(5'd9, 5'd10, 12'h654, 1'b1, acc);
    blank_i = 1'b1;
    wait_strobe(20);
    blank_i = 1'b0;
    @(negedge VGA_CTRL_CLK);
    check("hold_we_n", {31'b0, sram_we_n}, 32'd1);
    check("hold_own_oe", {30'b0, sram_own, sram_dq_oe}, 32'd3);
    check("hold_addr", {14'b0, sram_addr}, 32'h0E800);
    s0 = strobes;
    repeat (8) @(negedge VGA_CTRL_CLK);
    check("blank_wait_no_write", strobes - s0, 32'd0);
    check("blank_wait_busy", {31'b0, busy}, 32'd1);
    blank_i = 1'b1;
    wait_idle(20, "blank_drop_idle");

    // Whole-field clear followed by a queued write; a second clr_start mid-clear is ignored
    s0 = strobes;
    clr_color = 12'h000;
    @(negedge VGA_CTRL_CLK);
    clr_start = 1'b1;
    for (int y = 0; y < 22; y++)
      for (int x = 0; x < 20; x++)
        sb.push_back('{{5'(x), 5'(y), 8'h00}, 16'h0000});
    @(negedge VGA_CTRL_CLK);
    clr_start = 1'b0;
    push_entry(5'd2, 5'd3, 12'hF00, 1'b0, acc);
    sb.push_back('{18'h04300, 16'hF000});
    repeat (20) @(negedge VGA_CTRL_CLK);
    clr_color = 12'hFFF;
    clr_start = 1'b1;
    @(negedge VGA_CTRL_CLK);
    clr_start = 1'b0;
    wait_idle(2000, "clear_idle");
    check("clear_write_count", strobes - s0, 32'd441);

    // Asynchronous reset during STROBE discards the queue
    blank_i = 1'b0;
    push_entry(5'd11, 5'd12, 12'hAAA, 1'b1, acc);
    push_entry(5'd13, 5'd14, 12'hBBB, 1'b0, acc);
    blank_i = 1'b1;
    wait_strobe(20);
    #2 RST = 1'b0;
    #1;
    check("rst_async_we_n", {31'b0, sram_we_n}, 32'd1);
    check("rst_async_oe", {31'b0, sram_dq_oe}, 32'd0);
    check("rst_async_own", {31'b0, sram_own}, 32'd0);
    sb.delete();
    @(negedge VGA_CTRL_CLK);
    @(negedge VGA_CTRL_CLK);
    RST = 1'b1;
    s0 = strobes;
    repeat (20) @(negedge VGA_CTRL_CLK);
    check("post_rst_no_write", strobes - s0, 32'd0);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_ready", {31'b0, wr_ready}, 32'd1);

`ifdef FIELD_WR_BOUNDS_CHECK_EN
    // Out-of-range column is discarded and flagged until reset
    s0 = strobes;
    push_entry(5'd25, 5'd0, 12'h0F0, 1'b0, acc);
    repeat (10) @(negedge VGA_CTRL_CLK);
    check("oob_no_write", strobes - s0, 32'd0);
    check("oob_flag", {31'b0, err_oob}, 32'd1);
    check("oob_busy", {31'b0, busy}, 32'd0);
    RST = 1'b0;
    @(negedge VGA_CTRL_CLK);
    check("oob_cleared", {31'b0, err_oob}, 32'd0);
    RST = 1'b1;
    @(negedge VGA_CTRL_CLK);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
